// File: rtl/vin_pattern_gen_pkg.sv
// Shared types and helpers for the synthetic vin_* video source and its timing counter.
package caster_vin_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_COUNT = 2'd3
  } pat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned PIX_W = 32;
  localparam int unsigned FCNT_W = 16;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vin_pattern_gen_if.sv
// Video stream towards caster: syncs, data enable and one 32-bit pixel word per clock.
interface vin_pattern_gen_if;
  logic        vin_vsync;
  logic        vin_hsync;
  logic        vin_de;
  logic [31:0] vin_pixel;

  modport master (output vin_vsync, vin_hsync, vin_de, vin_pixel);
  modport slave  (input  vin_vsync, vin_hsync, vin_de, vin_pixel);
endinterface

// File: rtl/vin_timing_counter.sv
// Raster h/v counters with active/porch/sync decode; counters are held at zero while run is low.
module vin_timing_counter
  import caster_vin_pkg::*;
#(
  parameter int unsigned H_ACT  = 256,
  parameter int unsigned H_FP   = 8,
  parameter int unsigned H_SYNC = 4,
  parameter int unsigned H_BP   = 8,
  parameter int unsigned V_ACT  = 16,
  parameter int unsigned V_FP   = 2,
  parameter int unsigned V_SYNC = 1,
  parameter int unsigned V_BP   = 2,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [7:0] h_lo,
  output logic [7:0] v_lo,
  output logic       first,
  output logic       last,
  output logic       de,
  output logic       hsync,
  output logic       vsync
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = cnt_w(H_TOT);
  localparam int unsigned VW = cnt_w(V_TOT);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_act;
  logic          vs_act;

  assign h_wrap = (h_q == HW'(H_TOT - 1));
  assign v_wrap = (v_q == VW'(V_TOT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!run) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_wrap) begin
      h_q <= '0;
      v_q <= v_wrap ? '0 : v_q + VW'(1);
    end else begin
      h_q <= h_q + HW'(1);
    end
  end

  always_comb begin
    hs_act = (h_q >= HW'(H_ACT + H_FP)) && (h_q < HW'(H_ACT + H_FP + H_SYNC));
    vs_act = (v_q >= VW'(V_ACT + V_FP)) && (v_q < VW'(V_ACT + V_FP + V_SYNC));
    de     = (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
    hsync  = hs_act ? HS_POL : ~HS_POL;
    vsync  = vs_act ? VS_POL : ~VS_POL;
    first  = (h_q == '0) && (v_q == '0);
    last   = h_wrap && v_wrap;
    h_lo   = 8'(h_q);
    v_lo   = 8'(v_q);
  end

endmodule

// File: rtl/vin_pattern_gen.sv
// Synthetic video source for caster: run/idle FSM, per-frame mode/fg latch, pattern mux, registered outputs.
module vin_pattern_gen
  import caster_vin_pkg::*;
#(
  parameter int unsigned H_ACT  = 256,
  parameter int unsigned H_FP   = 8,
  parameter int unsigned H_SYNC = 4,
  parameter int unsigned H_BP   = 8,
  parameter int unsigned V_ACT  = 16,
  parameter int unsigned V_FP   = 2,
  parameter int unsigned V_SYNC = 1,
  parameter int unsigned V_BP   = 2,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  fg,
  vin_pattern_gen_if.master vin,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t             state_q;
  state_t             state_nxt;
  logic               run;
  logic [7:0]         h_lo;
  logic [7:0]         v_lo;
  logic               first;
  logic               last;
  logic               de_dec;
  logic               hs_dec;
  logic               vs_dec;
  logic [1:0]         mode_q;
  logic [PIX_W-1:0]   fg_q;
  logic [1:0]         mode_eff;
  logic [PIX_W-1:0]   fg_eff;
  logic [PIX_W-1:0]   pix_nxt;
  logic [FCNT_W-1:0]  frame_cnt_q;

  vin_timing_counter #(
    .H_ACT (H_ACT),  .H_FP  (H_FP),  .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT (V_ACT),  .V_FP  (V_FP),  .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .h_lo (h_lo),
    .v_lo (v_lo),
    .first(first),
    .last (last),
    .de   (de_dec),
    .hsync(hs_dec),
    .vsync(vs_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Leaving RUN is only possible on the last clock, so frames are never truncated.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (en)          state_nxt = ST_RUN;
      ST_RUN:  if (last && !en) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run = (state_q == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      fg_q   <= '0;
    end else if (run && first) begin
      mode_q <= mode;
      fg_q   <= fg;
    end
  end

  // At (0,0) the latch is being loaded this very clock, so use the live inputs.
  always_comb begin
    mode_eff = first ? mode : mode_q;
    fg_eff   = first ? fg   : fg_q;
    pix_nxt  = '0;
    if (de_dec) begin
      case (pat_t'(mode_eff))
        PAT_SOLID: pix_nxt = fg_eff;
        PAT_GRAD:  pix_nxt = {4{h_lo}};
        PAT_CHECK: pix_nxt = (h_lo[3] ^ v_lo[3]) ? fg_eff : ~fg_eff;
        PAT_COUNT: pix_nxt = {frame_cnt_q[7:0], 8'h00, v_lo, h_lo};
        default:   pix_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin.vin_vsync <= ~VS_POL;
      vin.vin_hsync <= ~HS_POL;
      vin.vin_de    <= 1'b0;
      vin.vin_pixel <= '0;
      frame_done    <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (run) begin
      vin.vin_vsync <= vs_dec;
      vin.vin_hsync <= hs_dec;
      vin.vin_de    <= de_dec;
      vin.vin_pixel <= pix_nxt;
      frame_done    <= last;
      if (last) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end else begin
      vin.vin_vsync <= ~VS_POL;
      vin.vin_hsync <= ~HS_POL;
      vin.vin_de    <= 1'b0;
      vin.vin_pixel <= '0;
      frame_done    <= 1'b0;
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule
